// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned MAX_BUS_W   = 256;
  localparam int unsigned MAX_FIELD_W = 64;

  // Field idx of width w from a flattened bus; caller narrows the result to w bits.
  function automatic logic [MAX_FIELD_W-1:0] bus_field(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    return MAX_FIELD_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/regfile_clr_ctrl.sv
// Clear engine: walks every entry to zero after reset or on request, then reports ready.
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  output logic                 ready_o,
  output logic                 clr_we_o,
  output logic [ADDRWIDTH-1:0] clr_addr_o
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = '1;

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
  logic                 ready_q, ready_d;
  logic                 clr_we_q, clr_we_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      ready_q  <= 1'b0;
      clr_we_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ready_q  <= ready_d;
      clr_we_q <= clr_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clear_i) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDRWIDTH'(1);
        end
      end
      ST_RUN: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    ready_d  = 1'b0;
    clr_we_d = 1'b0;
    if (state_d == ST_RUN) ready_d  = 1'b1;
    else                   clr_we_d = 1'b1;
  end

  assign ready_o    = ready_q;
  assign clr_we_o   = clr_we_q;
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD async reads, two sync writes, optional bypass and zero entry.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 5,
  parameter int unsigned NREAD     = 2,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  output logic                       ready,
  input  logic [NREAD*ADDRWIDTH-1:0] raddr,
  output logic [NREAD*DATAWIDTH-1:0] rdata,
  input  logic                       we0,
  input  logic [ADDRWIDTH-1:0]       waddr0,
  input  logic [DATAWIDTH-1:0]       wdata0,
  input  logic                       we1,
  input  logic [ADDRWIDTH-1:0]       waddr1,
  input  logic [DATAWIDTH-1:0]       wdata1
);

  localparam int unsigned DEPTH = 1 << ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic                 clr_we;
  logic [ADDRWIDTH-1:0] clr_addr;
  logic                 wr_ok_c;
  logic                 we0_c;
  logic                 we1_c;

  regfile_clr_ctrl #(
    .ADDRWIDTH (ADDRWIDTH)
  ) u_clr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Writes land only in RUN and are dropped on the cycle a clear or reset is requested.
  assign wr_ok_c = ready & ~clear & ~rst;
  assign we0_c   = we0 & wr_ok_c & ~((ZERO_REG != 0) && (waddr0 == '0));
  assign we1_c   = we1 & wr_ok_c & ~((ZERO_REG != 0) && (waddr1 == '0));

  // No reset on the array itself; port 1 is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (we0_c) mem_q[waddr0] <= wdata0;
      if (we1_c) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDRWIDTH-1:0] ra_c;
    logic [DATAWIDTH-1:0] rd_c;

    always_comb begin
      ra_c = ADDRWIDTH'(bus_field(MAX_BUS_W'(raddr), k, ADDRWIDTH));
      rd_c = mem_q[ra_c];
      if (BYPASS != 0) begin
        if (we0_c && (waddr0 == ra_c)) rd_c = wdata0;
        if (we1_c && (waddr1 == ra_c)) rd_c = wdata1;
      end
      if (!ready || ((ZERO_REG != 0) && (ra_c == '0))) rd_c = '0;
    end

    assign rdata[k*DATAWIDTH +: DATAWIDTH] = rd_c;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing/zero-reg instance and a plain instance side by side.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  waddr0 = '0, waddr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [4:0]  ra0 = '0, ra1 = '0;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic        ready_a, ready_b;
  logic [31:0] a0, a1, b0, b1;

  int tests_run = 0;
  int tests_failed = 0;

  assign raddr = {ra1, ra0};
  assign a0 = rdata_a[31:0];
  assign a1 = rdata_a[63:32];
  assign b0 = rdata_b[31:0];
  assign b1 = rdata_b[63:32];

  always #5 clk = ~clk;

  regfile_mp #(.DATAWIDTH(32), .ADDRWIDTH(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ready(ready_a),
    .raddr(raddr), .rdata(rdata_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
  );

  regfile_mp #(.DATAWIDTH(32), .ADDRWIDTH(5), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clear(clear), .ready(ready_b),
    .raddr(raddr), .rdata(rdata_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (ready_a !== 1'b0 || a0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b rdata0=%h, expected ready=0 rdata0=0", ready_a, a0);
    end
    rst = 1'b0;
    n = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 32 || ready_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_clear_len: ready after %0d cycles (ready_b=%b), expected 32", n, ready_b);
    end
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i);
      ra1 = 5'(31 - i);
      #1;
      tests_run++;
      if (a0 !== 32'h0 || a1 !== 32'h0 || b0 !== 32'h0 || b1 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_zero[%0d]: a0=%h a1=%h b0=%h b1=%h, expected all 0", i, a0, a1, b0, b1);
      end
    end
  endtask

  task automatic test_bypass();
    ra0 = 5'd5;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (a0 !== 32'hDEADBEEF || b0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: byp=%h nobyp=%h, expected deadbeef / 0", a0, b0);
    end
    tick();
    we0 = 1'b0;
    #1;
    tests_run++;
    if (a0 !== 32'hDEADBEEF || b0 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL bypass_next_cycle: byp=%h nobyp=%h, expected deadbeef", a0, b0);
    end
    ra1 = 5'd5;
    #1;
    tests_run++;
    if (a1 !== a0 || a1 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL same_raddr: port1=%h port0=%h, expected deadbeef on both", a1, a0);
    end
  endtask

  task automatic test_write_collision();
    ra1 = 5'd7;
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    #1;
    tests_run++;
    if (a1 !== 32'h22 || b1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL collision_bypass: byp=%h nobyp=%h, expected 22 / 0", a1, b1);
    end
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    tests_run++;
    if (a1 !== 32'h22 || b1 !== 32'h22) begin
      tests_failed++;
      $display("FAIL collision_commit: byp=%h nobyp=%h, expected 22", a1, b1);
    end
  endtask

  task automatic test_zero_reg();
    ra0 = 5'd0;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    #1;
    tests_run++;
    if (a0 !== 32'h0 || b0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_reg_bypass: zr=%h plain=%h, expected 0 / 0", a0, b0);
    end
    tick();
    we1 = 1'b0;
    #1;
    tests_run++;
    if (a0 !== 32'h0 || b0 !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL zero_reg_commit: zr=%h plain=%h, expected 0 / ffffffff", a0, b0);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
      tick();
    end
    we0 = 1'b0;
    ra0 = 5'd3; ra1 = 5'd31;
    #1;
    tests_run++;
    if (a0 !== 32'd3 || a1 !== 32'd31 || b1 !== 32'd31) begin
      tests_failed++;
      $display("FAIL fill: e3=%h e31=%h e31b=%h, expected 3 / 1f / 1f", a0, a1, b1);
    end
    clear = 1'b1;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAAAA;
    tick();
    clear = 1'b0; we0 = 1'b0;
    tests_run++;
    if (ready_a !== 1'b0 || a0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL clear_ready_fall: ready=%b rdata=%h, expected 0 / 0", ready_a, a0);
    end
    n = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 32) begin
      tests_failed++;
      $display("FAIL clear_len: ready after %0d cycles, expected 32", n);
    end
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i);
      ra1 = 5'(i);
      #1;
      tests_run++;
      if (a0 !== 32'h0 || b1 !== 32'h0) begin
        tests_failed++;
        $display("FAIL clear_zero[%0d]: byp=%h plain=%h, expected 0", i, a0, b1);
      end
    end
  endtask

  task automatic test_rst_mid_clear();
    int n;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ra0 = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (a0 !== 32'h0 || ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_no_bypass: rdata=%h ready=%b, expected 0 / 0", a0, ready_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear_ready: ready=%b, expected 0", ready_a);
    end
    n = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    we0 = 1'b0;
    #1;
    tests_run++;
    if (n !== 32) begin
      tests_failed++;
      $display("FAIL rst_mid_clear_len: ready after %0d cycles, expected 32", n);
    end
    tests_run++;
    if (a0 !== 32'h0 || b0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL write_during_clear: byp=%h plain=%h, expected 0", a0, b0);
    end
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h1234;
    tick();
    we1 = 1'b0;
    #1;
    tests_run++;
    if (a0 !== 32'h1234 || b0 !== 32'h1234) begin
      tests_failed++;
      $display("FAIL write_after_rst: byp=%h plain=%h, expected 1234", a0, b0);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_write_collision();
    test_zero_reg();
    test_clear();
    test_rst_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
